bin_bcd_serializer: RTL

Upstream feeder for the digit-to-ASCII converter in the UART result path. It latches an unsigned binary word (the ALU result) and converts it to BCD using sequential double-dabble, one shift per clock. It then presents the decimal digits MSB-first, one per valid/ready handshake, on a 4-bit digit bus. That bus drives the ASCII converter, whose output feeds the UART transmitter.

---
 rtl/bin_bcd_serializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bin_bcd_serializer.sv
// Binary-to-BCD converter (sequential double-dabble, one shift per clock)
// followed by an MSB-first digit serializer with a valid/ready handshake.
module bin_bcd_serializer #(
  parameter int DATA_W         = 8,
  parameter int NDIG           = 3,
  parameter int SUPRIMIR_CEROS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dato,
  output logic [3:0]        digito,
  output logic              digito_valid,
  input  logic              digito_ready,
  output logic              ultimo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BCD_W = 4 * NDIG;

  typedef enum logic [1:0] {IDLE, CONV, SEND, FIN} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          digito_q, digito_d;
  logic                valid_q, valid_d;
  logic                ultimo_q, ultimo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BCD_W+DATA_W-1:0] cat_w;
  logic [IDX_W-1:0]        lead_w;
  logic [IDX_W-1:0]        nidx_w;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] nib(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] i);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (i == IDX_W'(k)) r = b[4*k +: 4];
    end
    return r;
  endfunction

  // First digit to send: highest nonzero nibble (digit 0 for a zero value),
  // or always the top digit when leading zeros are kept.
  function automatic logic [IDX_W-1:0] lead_idx(input logic [BCD_W-1:0] b);
    logic [IDX_W-1:0] r;
    r = '0;
    if (SUPRIMIR_CEROS == 0) begin
      r = IDX_W'(NDIG - 1);
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (b[4*i +: 4] != 4'd0) r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    digito_d = digito_q;
    valid_d  = valid_q;
    ultimo_d = ultimo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cat_w    = {dabble_adj(bcd_q), shift_q} << 1;
    lead_w   = lead_idx(bcd_q);
    nidx_w   = idx_q - IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = dato;
          bcd_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = cat_w[BCD_W+DATA_W-1:DATA_W];
        shift_d = cat_w[DATA_W-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = SEND;
      end
      SEND: begin
        if (!valid_q) begin
          // BCD is final here; present the leading digit.
          idx_d    = lead_w;
          digito_d = nib(bcd_q, lead_w);
          valid_d  = 1'b1;
          ultimo_d = (lead_w == '0);
        end else if (digito_ready) begin
          if (idx_q == '0) begin
            digito_d = 4'd0;
            valid_d  = 1'b0;
            ultimo_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = FIN;
          end else begin
            idx_d    = nidx_w;
            digito_d = nib(bcd_q, nidx_w);
            ultimo_d = (nidx_w == '0);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      digito_q <= 4'd0;
      valid_q  <= 1'b0;
      ultimo_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      digito_q <= digito_d;
      valid_q  <= valid_d;
      ultimo_q <= ultimo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign digito       = digito_q;
  assign digito_valid = valid_q;
  assign ultimo       = ultimo_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
